ones_gap_extractor: RTL and testbench
=====================================

// Module: ones_gap_extractor
// PURPOSE
//  Consumes the W-bit mask of the first N set bits produced by the
//  n-ones finder in the unary/Rice decode path.
//  Serialises the mask MSB-first: one beat per set bit, carrying its
//  bit position and the zero-run (unary gap) above it.
//  Feeds the remainder/symbol assembly stage.
//  Valid/ready on both sides; one beat per cycle at full throughput.
// PARAMETERS
//  W   8            mask width
//  N   2            max ones per mask guaranteed by upstream
//  IW  $clog2(W+1)  width of position/gap fields (derived, not overridden)
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   async active-low reset
//  in_valid      in   1   mask available
//  in_ready      out  1   mask accepted when in_valid&&in_ready
//  in_mask       in   W   mask of first N ones
//  out_valid     out  1   beat available
//  out_ready     in   1   beat consumed when out_valid&&out_ready
//  out_pos       out  IW  bit index of this one (W-1..0)
//  out_gap       out  IW  zeros between this one and previous one (or mask MSB)
//  out_last      out  1   final beat of current mask
//  out_none      out  1   beat represents an all-zero mask
//  err_overflow  out  1   sticky: a mask held more than N ones
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, mask reg=0, beat cnt=0, prev=W.
//    Output values under reset: out_valid=0, out_pos=0, out_gap=0,
//    out_last=0, out_none=0, err_overflow=0. in_ready=1 once IDLE.
//  - FSM IDLE/EMIT.
//    IDLE: in_ready=1; accept -> latch mask, prev=W, cnt=0 -> EMIT.
//    EMIT: out_valid=1.
//  - Per-beat computation:
//      p   = index of the highest set bit of the mask reg.
//      out_pos = p; out_gap = prev-1-p.
//      On handshake: clear bit p, prev=p, cnt++.
//  - out_last=1 when either condition holds: remaining mask (after
//    clearing p) ==0, or cnt==N-1.
//  - Handshake on the last beat: return to IDLE, or take a new mask in
//    the same cycle. in_ready = IDLE || (out_valid&&out_ready&&out_last).
//    Back-to-back masks incur no bubble.
//  - Latency: mask accepted in cycle t -> first beat valid in cycle t+1.
//    A mask with k ones (1<=k<=N) takes k beats.
//  - All-zero mask: exactly one beat, out_none=1, out_pos=0, out_gap=W,
//    out_last=1.
//  - Mask with more than N ones: only the first N beats are emitted.
//    The remaining ones are dropped, err_overflow is set, and it is
//    cleared only by reset.
//  - Backpressure: out_pos/out_gap/out_last/out_none hold stable while
//    out_valid && !out_ready.
//  - Reset mid-EMIT: beat and stored mask are discarded immediately;
//    no partial beat is emitted after release.
//  - All arithmetic is unsigned IW-bit; prev-1-p never underflows
//    because p<prev.
// CONFIGURATION
//  ONES_GAP_TAIL_EN defined:
//    - Adds output port out_tail (1 bit).
//    - After the final one-beat, emits one extra beat: out_tail=1,
//      out_pos=0, out_gap=p_last (zeros below the last one),
//      out_last=1. The one-beat then has out_last=0.
//    - All-zero mask: single beat, out_none=1, no tail beat.
//  ONES_GAP_TAIL_EN undefined:
//    - No out_tail port and no tail beat; behaviour as above.
// TESTING (W=8, N=2)
//  1 in_mask=0100_1000, out_ready=1
//    -> (pos6,gap1,last0), (pos3,gap2,last1); in_ready high with last beat.
//  2 in_mask=1000_0000
//    -> one beat (pos7,gap0,last1); next mask accepted same cycle.
//  3 in_mask=0000_0000
//    -> one beat (none1,pos0,gap8,last1).
//  4 in_mask=1010_1000
//    -> (pos7,gap0), (pos5,gap1,last1); err_overflow=1, stays 1.
//  5 mask 0100_1000 with out_ready=0 for 3 cycles
//    -> first beat held stable, in_ready=0; then completes normally.
//  6 rst_n low during 2nd beat
//    -> out_valid=0 at once; after release, in_ready=1, no stale beat.
//    With ONES_GAP_TAIL_EN, case 1 appends (tail1,pos0,gap3,last1).

Source files
------------

// File: rtl/ones_gap_if.sv
// ones_gap_if: mask-in / beat-out stream bundle for ones_gap_extractor (out_tail present when ONES_GAP_TAIL_EN is defined)
interface ones_gap_if #(parameter int W = 8);
  localparam int IW = $clog2(W + 1);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_mask;
  logic out_valid;
  logic out_ready;
  logic [IW-1:0] out_pos;
  logic [IW-1:0] out_gap;
  logic out_last;
  logic out_none;
  logic err_overflow;
`ifdef ONES_GAP_TAIL_EN
  logic out_tail;
  modport master(output in_valid, in_mask, out_ready,
                 input in_ready, out_valid, out_pos, out_gap, out_last, out_none, err_overflow, out_tail);
  modport slave(input in_valid, in_mask, out_ready,
                output in_ready, out_valid, out_pos, out_gap, out_last, out_none, err_overflow, out_tail);
`else
  modport master(output in_valid, in_mask, out_ready,
                 input in_ready, out_valid, out_pos, out_gap, out_last, out_none, err_overflow);
  modport slave(input in_valid, in_mask, out_ready,
                output in_ready, out_valid, out_pos, out_gap, out_last, out_none, err_overflow);
`endif
endinterface

// File: rtl/ones_gap_extractor.sv
// ones_gap_extractor: serialises a mask MSB-first into (position, zero-gap) beats; ONES_GAP_TAIL_EN adds a trailing tail beat
module ones_gap_extractor #(
  parameter int W = 8,
  parameter int N = 2
) (
  input logic clk,
  input logic rst_n,
  ones_gap_if.slave bus
);
  localparam int IW = $clog2(W + 1);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, EMIT, TAIL} state_t;
  state_t state, state_n;
  logic [W-1:0] mask, rem;
  logic [IW-1:0] prev, p;
  logic [CW-1:0] cnt;
  logic err, emit, none, one_last, fire_in, fire_out, tail_go;
  // highest set bit of the held mask; later iterations override earlier ones
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) if (mask[i]) p = IW'(i);
  end
  assign emit = state == EMIT;
  assign rem = mask & ~(W'(1) << p);
  assign none = emit && mask == '0;
  assign one_last = rem == '0 || cnt == CW'(N - 1);
  assign bus.out_valid = state != IDLE;
  assign fire_out = bus.out_valid && bus.out_ready;
  assign bus.in_ready = state == IDLE || (fire_out && bus.out_last);
  assign fire_in = bus.in_valid && bus.in_ready;
  assign bus.out_none = none;
  assign bus.out_pos = emit ? p : '0;
  assign bus.out_gap = none ? IW'(W) : emit ? prev - IW'(1) - p : state == TAIL ? prev : '0;
  assign bus.err_overflow = err;
`ifdef ONES_GAP_TAIL_EN
  assign bus.out_tail = state == TAIL;
  assign bus.out_last = state == TAIL || none;
  assign tail_go = emit && fire_out && one_last && !none;
`else
  assign bus.out_last = emit && one_last;
  assign tail_go = 1'b0;
`endif
  // next state: a new mask wins, otherwise tail beat, otherwise drop to idle after the last beat
  always_comb begin
    state_n = fire_in ? EMIT : tail_go ? TAIL : (fire_out && bus.out_last) ? IDLE : state;
  end
  // state, working mask, previous position, beat count and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mask <= '0;
      prev <= IW'(W);
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      err <= err | (emit && fire_out && cnt == CW'(N - 1) && rem != '0);
      if (fire_in) begin
        mask <= bus.in_mask;
        prev <= IW'(W);
        cnt <= '0;
      end else if (emit && fire_out) begin
        mask <= rem;
        prev <= p;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ones_gap_extractor.sv
// tb_ones_gap_extractor: directed checks of ones_gap_extractor with W=8, N=2
module tb_ones_gap_extractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  ones_gap_if #(.W(8)) bus ();
  ones_gap_extractor #(.W(8), .N(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input string tag, input int pos, input int gap, input logic last, input logic none);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".pos"}, 32'(bus.out_pos), 32'(pos));
    chk({tag, ".gap"}, 32'(bus.out_gap), 32'(gap));
    chk({tag, ".last"}, 32'(bus.out_last), 32'(last));
    chk({tag, ".none"}, 32'(bus.out_none), 32'(none));
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_mask = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.pos", 32'(bus.out_pos), 32'd0);
    chk("rst.gap", 32'(bus.out_gap), 32'd0);
    chk("rst.last", 32'(bus.out_last), 32'd0);
    chk("rst.none", 32'(bus.out_none), 32'd0);
    chk("rst.err", 32'(bus.err_overflow), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_mask = 8'b0100_1000;
    @(negedge clk);
    beat("c1.b0", 6, 1, 1'b0, 1'b0);
    chk("c1.b0.in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    beat("c1.b1", 3, 2, 1'b1, 1'b0);
    chk("c1.b1.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("c1.idle.valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_mask = 8'b1000_0000;
    @(negedge clk);
    beat("c2.b0", 7, 0, 1'b1, 1'b0);
    chk("c2.in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_mask = 8'b0000_0000;
    @(negedge clk);
    beat("c3.b0", 0, 8, 1'b1, 1'b1);
    chk("c3.in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_mask = 8'b1010_1000;
    @(negedge clk);
    beat("c4.b0", 7, 0, 1'b0, 1'b0);
    chk("c4.b0.err", 32'(bus.err_overflow), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    beat("c4.b1", 5, 1, 1'b1, 1'b0);
    @(negedge clk);
    chk("c4.idle.valid", 32'(bus.out_valid), 32'd0);
    chk("c4.err", 32'(bus.err_overflow), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_mask = 8'b0100_1000;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat("c5.hold", 6, 1, 1'b0, 1'b0);
      chk("c5.hold.in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    beat("c5.b0", 6, 1, 1'b0, 1'b0);
    @(negedge clk);
    beat("c5.b1", 3, 2, 1'b1, 1'b0);
    @(negedge clk);
    chk("c5.idle.valid", 32'(bus.out_valid), 32'd0);
    chk("c5.err", 32'(bus.err_overflow), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_mask = 8'b0100_1000;
    @(negedge clk);
    beat("c6.b0", 6, 1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    beat("c6.b1", 3, 2, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("c6.rst.valid", 32'(bus.out_valid), 32'd0);
    chk("c6.rst.err", 32'(bus.err_overflow), 32'd0);
    chk("c6.rst.last", 32'(bus.out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("c6.post.in_ready", 32'(bus.in_ready), 32'd1);
    chk("c6.post.valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("c6.post2.valid", 32'(bus.out_valid), 32'd0);
    chk("c6.post2.pos", 32'(bus.out_pos), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
